reset_sequencer: RTL

Power-up and recovery controller for the USB-clock domain. It watches the PLL lock, then releases resets in a fixed order: the core (USB/terminal) first, then the video path. It also generates the half-rate VGA clock enable and gives the terminal core a soft-reset request/acknowledge path. It replaces ad-hoc reset counters at the top level and re-sequences the design from scratch whenever PLL lock is lost.

---
 rtl/reset_seq_pkg.sv | 29 ++
 rtl/reset_sequencer_if.sv | 21 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/reset_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the USB-domain reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_REL_CORE  = 3'd2,
    ST_REL_VIDEO = 3'd3,
    ST_RUN       = 3'd4,
    ST_SOFT      = 3'd5
  } seq_state_e;

  localparam int unsigned DEF_LOCK_FILTER = 8;
  localparam int unsigned DEF_HOLD_CYCLES = 32;
  localparam int unsigned DEF_STAGE_GAP   = 16;

  // One width covers every counter; the filter counter must hold LOCK_FILTER
  // itself, hence the +1.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Lock, soft-reset handshake and reset/enable outputs of the sequencer.
interface reset_sequencer_if;
  logic       pll_locked;
  logic       soft_req;
  logic       soft_ack;
  logic       reset_core;
  logic       reset_video;
  logic       vga_ce;
  logic       lock_lost;
  logic [2:0] seq_state;

  modport master (
    input  pll_locked, soft_req,
    output soft_ack, reset_core, reset_video, vga_ce, lock_lost, seq_state
  );

  modport slave (
    output pll_locked, soft_req,
    input  soft_ack, reset_core, reset_video, vga_ce, lock_lost, seq_state
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs, cleared by reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Power-up / lock-loss reset sequencer for the USB clock domain.
//
// state     | meaning
// ----------+-------------------------------------------------------
// WAIT_LOCK | all resets held, filtering synchronized PLL lock
// HOLD      | lock accepted, all resets held HOLD_CYCLES
// REL_CORE  | core released, video held STAGE_GAP
// REL_VIDEO | video still held, vga_ce toggling, STAGE_GAP
// RUN       | everything released, soft_req honoured
// SOFT      | one-cycle soft reset, soft_ack pulse, then HOLD
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned STAGE_GAP   = DEF_STAGE_GAP
) (
  input  logic               clk_usb,
  input  logic               reset_usb_n,
  reset_sequencer_if.master  bus
);

  localparam int unsigned CW = cnt_width(LOCK_FILTER, HOLD_CYCLES, STAGE_GAP);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] filter_q, filter_d;
  logic          lock_sync;
  logic          reset_core_q, reset_core_d;
  logic          reset_video_q, reset_video_d;
  logic          vga_ce_q, vga_ce_d;
  logic          soft_ack_q, soft_ack_d;
  logic          lock_lost_q, lock_lost_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i   (clk_usb),
    .rst_n_i (reset_usb_n),
    .d_i     (bus.pll_locked),
    .q_o     (lock_sync)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk_usb) begin
    if (!reset_usb_n) begin
      state_q       <= ST_WAIT_LOCK;
      cnt_q         <= '0;
      filter_q      <= '0;
      reset_core_q  <= 1'b1;
      reset_video_q <= 1'b1;
      vga_ce_q      <= 1'b0;
      soft_ack_q    <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      filter_q      <= filter_d;
      reset_core_q  <= reset_core_d;
      reset_video_q <= reset_video_d;
      vga_ce_q      <= vga_ce_d;
      soft_ack_q    <= soft_ack_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  // Next state, counters, and outputs derived from the next state so every
  // output changes on the same edge as seq_state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    filter_d      = filter_q;
    lock_lost_d   = lock_lost_q;
    reset_core_d  = 1'b1;
    reset_video_d = 1'b1;
    vga_ce_d      = 1'b0;
    soft_ack_d    = 1'b0;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (!lock_sync) filter_d = '0;
        else if (filter_q == CW'(LOCK_FILTER)) state_d = ST_HOLD;
        else filter_d = filter_q + 1'b1;
      end
      ST_HOLD:      if (cnt_q == CW'(HOLD_CYCLES - 1)) state_d = ST_REL_CORE;
      ST_REL_CORE:  if (cnt_q == CW'(STAGE_GAP - 1))   state_d = ST_REL_VIDEO;
      ST_REL_VIDEO: if (cnt_q == CW'(STAGE_GAP - 1))   state_d = ST_RUN;
      ST_RUN:       if (bus.soft_req)                  state_d = ST_SOFT;
      ST_SOFT:      state_d = ST_HOLD;
      default:      state_d = ST_WAIT_LOCK;
    endcase

    // Lock loss outranks any sequencing decision, including soft_req.
    if (state_q != ST_WAIT_LOCK && !lock_sync) begin
      state_d     = ST_WAIT_LOCK;
      lock_lost_d = 1'b1;
    end

    // RUN and WAIT_LOCK hold the counter so it cannot wrap while idle.
    if (state_d != state_q) begin
      cnt_d    = '0;
      filter_d = '0;
    end else if (state_q inside {ST_HOLD, ST_REL_CORE, ST_REL_VIDEO}) begin
      cnt_d = cnt_q + 1'b1;
    end

    reset_core_d  = !(state_d inside {ST_REL_CORE, ST_REL_VIDEO, ST_RUN});
    reset_video_d = (state_d != ST_RUN);
    soft_ack_d    = (state_d == ST_SOFT);
    // vga_ce starts high on entry to REL_VIDEO and keeps its phase into RUN.
    if (state_d inside {ST_REL_VIDEO, ST_RUN})
      vga_ce_d = (state_q inside {ST_REL_VIDEO, ST_RUN}) ? ~vga_ce_q : 1'b1;
  end

  assign bus.seq_state   = state_q;
  assign bus.reset_core  = reset_core_q;
  assign bus.reset_video = reset_video_q;
  assign bus.vga_ce      = vga_ce_q;
  assign bus.soft_ack    = soft_ack_q;
  assign bus.lock_lost   = lock_lost_q;

endmodule
